hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Sequential hazard and stall scheduler for the 5-stage pipeline. It tracks in-flight register writes for the EXE, MEM and WB stages in a 3-entry scoreboard and drives `hazard_detected` into the decode controller to insert bubbles. It also flushes wrong-path instructions on taken branches and freezes the pipeline while data memory is busy. With forwarding compiled in, it also produces registered operand-forwarding selects for the EXE stage.

## Interface
- `REG_ADDR_W`, 5: register index width
- `STALL_CNT_W`, 16: width of the stall-cycle counter
- `clk`  in  1  pipeline clock, rising edge
- `rst`  in  1  reset; asynchronous, active-low (0 = reset)
- `id_src1`  in  REG_ADDR_W  ID-stage first source register
- `id_src2`  in  REG_ADDR_W  ID-stage second source register
- `id_two_src`  in  1  src2 is read (R-type, ST, BNE)
- `id_valid`  in  1  ID holds a real instruction
- `id_wb_en`  in  1  ID instruction writes a register
- `id_mem_r_en`  in  1  ID instruction is a load
- `id_dest`  in  REG_ADDR_W  ID destination register
- `branch_taken`  in  1  EXE resolved a taken branch this cycle
- `mem_ready`  in  1  data memory completes this cycle (0 = busy)
- `hazard_detected`  out  1  combinational; stall IF/ID, bubble into EXE
- `flush`  out  1  combinational; squash IF/ID
- `freeze`  out  1  combinational; hold all pipeline registers
- `fwd_src1_sel`  out  2  registered; 00 regfile, 01 MEM-stage result, 10 WB-stage result
- `fwd_src2_sel`  out  2  same encoding, for src2
- `stall_count`  out  STALL_CNT_W  saturating count of hazard stall cycles

## Operation
- Scoreboard entries are EXE, MEM and WB. Each entry holds {valid, wb_en, dest, is_load}.
- A match against an entry requires: entry valid, entry wb_en, entry dest == src, src != 0. Register 0 never matches.
- Src2 is compared only when `id_two_src` = 1.
- The register file is write-first. A WB-stage match is therefore never a hazard.
- `freeze` = !mem_ready.
- `flush` = branch_taken. When `flush` = 1, `hazard_detected` is forced to 0.
- `hazard_detected` = id_valid & !flush & (any src match against EXE or MEM). Forwarding changes this rule; see Configuration.
- Advance happens on a rising edge when freeze = 0:
  - WB ← MEM, MEM ← EXE.
  - EXE ← bubble if hazard_detected, flush, or !id_valid.
  - Otherwise EXE ← {1, id_wb_en, id_dest, id_mem_r_en}.
- When freeze = 1, all entries, fwd selects and `stall_count` hold their values.
- `stall_count` increments on each advancing edge where hazard_detected = 1. It saturates at all-ones.
- Simultaneous branch_taken and mem_ready = 0: freeze dominates and nothing advances. `flush` stays high until the advancing edge; the branch unit holds branch_taken meanwhile.

## Timing
- Reset: all entries are invalid with zero fields. `fwd_src*_sel` = 00 and `stall_count` = 0.
- Reset is asynchronous; mid-operation assertion clears all state immediately. After release, the combinational outputs follow the inputs.
- hazard/flush/freeze have zero-cycle latency from their inputs.
- Fwd selects are computed from ID and the scoreboard, then registered on the advancing edge. They are valid during the cycle the instruction occupies EXE.
- A load-use stall lasts 1 cycle with forwarding and 2 cycles without.

## Configuration
- `HAZARD_FORWARDING_EN` defined:
  - hazard_detected = id_valid & !flush & (src match against EXE entry with is_load = 1).
  - Registered selects use priority EXE match → 01, else MEM match → 10, else 00.
- `HAZARD_FORWARDING_EN` undefined:
  - The EXE/MEM match rule above applies.
  - Fwd selects are tied to 00 and no select registers are built.

## Structure
- The shared defines file holds the fwd-select encodings (`FWD_REGFILE`, `FWD_MEM`, `FWD_WB`) and the scoreboard entry field widths.
- One sub-module, `sb_match`, takes one src and one entry and outputs a hit. It is instantiated once per (src, entry) pair.

## Test plan
- Reset: rst = 0 mid-run with EXE valid → all outputs 0 immediately; entries invalid after release.
- ADD r3 then ADD r4,r3,r1 back-to-back, forwarding off → hazard_detected = 1 for 2 cycles; stall_count = 2.
- Same sequence, forwarding on → no hazard; fwd_src1_sel = 01 while the consumer is in EXE.
- LD r5 then SUB r6,r5,r5, forwarding on → 1 stall cycle, then fwd_src1_sel = fwd_src2_sel = 10.
- ADDI r0 then ADD r7,r0,r0 → never a hazard.
- branch_taken = 1 with a dependent ID instruction → flush = 1, hazard_detected = 0, bubble enters EXE.
- mem_ready = 0 for 3 cycles during a stall → freeze = 1 and stall_count unchanged; normal resumption afterwards.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and scoreboard layout for hazard_scoreboard.
// HAZARD_FORWARDING_EN selects load-use-only stalls plus forwarding.
package hazard_scoreboard_pkg;

  localparam int SB_ENTRIES = 3;
  localparam int SB_DEST_W  = 5;
  localparam int SB_FLAG_W  = 1;

  localparam int ST_EXE = 0;
  localparam int ST_MEM = 1;
  localparam int ST_WB  = 2;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REGFILE = 2'b00;
  localparam fwd_sel_t FWD_MEM     = 2'b01;
  localparam fwd_sel_t FWD_WB      = 2'b10;

  // Stages whose plain or load hits stall ID
`ifdef HAZARD_FORWARDING_EN
  localparam logic [SB_ENTRIES-1:0] HIT_MASK  = 3'b000;
  localparam logic [SB_ENTRIES-1:0] LOAD_MASK = 3'b001;
`else
  localparam logic [SB_ENTRIES-1:0] HIT_MASK  = 3'b011;
  localparam logic [SB_ENTRIES-1:0] LOAD_MASK = 3'b000;
`endif

  // hit[0] = EXE producer, hit[1] = MEM producer
  function automatic fwd_sel_t fwd_pick(
    input logic [1:0] hit
  );
    fwd_sel_t sel;
    sel = FWD_REGFILE;
    if (hit[0])
      sel = FWD_MEM;
    else if (hit[1])
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// One source register compared against one scoreboard entry.
// Register 0 never matches.
module sb_match #(
  parameter int W = 5
) (
  input  logic [W-1:0] src,
  input  logic         e_valid,
  input  logic         e_wb_en,
  input  logic         e_load,
  input  logic [W-1:0] e_dest,
  output logic         hit,
  output logic         load_hit
);

  assign hit = e_valid & e_wb_en
             & (src != '0)
             & (e_dest == src);

  assign load_hit = hit & e_load;

endmodule

// File: rtl/hazard_scoreboard.sv
// EXE/MEM/WB write scoreboard: stall, flush and freeze control.
// HAZARD_FORWARDING_EN adds registered operand-forwarding selects.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W  = SB_DEST_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  id_src1,
  input  logic [REG_ADDR_W-1:0]  id_src2,
  input  logic                   id_two_src,
  input  logic                   id_valid,
  input  logic                   id_wb_en,
  input  logic                   id_mem_r_en,
  input  logic [REG_ADDR_W-1:0]  id_dest,
  input  logic                   branch_taken,
  input  logic                   mem_ready,
  output logic                   hazard_detected,
  output logic                   flush,
  output logic                   freeze,
  output logic [1:0]             fwd_src1_sel,
  output logic [1:0]             fwd_src2_sel,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic [SB_ENTRIES-1:0] sb_valid;
  logic [SB_ENTRIES-1:0] sb_wb_en;
  logic [SB_ENTRIES-1:0] sb_load;
  logic [SB_ENTRIES-1:0][REG_ADDR_W-1:0] sb_dest;

  logic [SB_ENTRIES-1:0] hit1;
  logic [SB_ENTRIES-1:0] hit2;
  logic [SB_ENTRIES-1:0] ld1;
  logic [SB_ENTRIES-1:0] ld2;
  logic [SB_ENTRIES-1:0] hit2_g;
  logic [SB_ENTRIES-1:0] ld2_g;
  logic [SB_ENTRIES-1:0] stall_vec;

  logic advance;
  logic bubble;

  for (genvar e = 0; e < SB_ENTRIES; e++) begin : g_match
    sb_match #(.W(REG_ADDR_W)) u_m1 (
      .src      (id_src1),
      .e_valid  (sb_valid[e]),
      .e_wb_en  (sb_wb_en[e]),
      .e_load   (sb_load[e]),
      .e_dest   (sb_dest[e]),
      .hit      (hit1[e]),
      .load_hit (ld1[e])
    );
    sb_match #(.W(REG_ADDR_W)) u_m2 (
      .src      (id_src2),
      .e_valid  (sb_valid[e]),
      .e_wb_en  (sb_wb_en[e]),
      .e_load   (sb_load[e]),
      .e_dest   (sb_dest[e]),
      .hit      (hit2[e]),
      .load_hit (ld2[e])
    );
  end

  assign hit2_g = hit2 & {SB_ENTRIES{id_two_src}};
  assign ld2_g  = ld2 & {SB_ENTRIES{id_two_src}};

  // WB hits are masked off: the regfile is write-first
  assign stall_vec = ((hit1 | hit2_g) & HIT_MASK)
                   | ((ld1 | ld2_g) & LOAD_MASK);

  assign flush  = branch_taken;
  assign freeze = ~mem_ready;

  assign hazard_detected = id_valid & ~flush
                         & (|stall_vec);

  assign advance = mem_ready;
  assign bubble  = hazard_detected | flush | ~id_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_valid    <= '0;
      sb_wb_en    <= '0;
      sb_load     <= '0;
      sb_dest     <= '0;
      stall_count <= '0;
    end else if (advance) begin
      sb_valid[ST_WB]  <= sb_valid[ST_MEM];
      sb_wb_en[ST_WB]  <= sb_wb_en[ST_MEM];
      sb_load[ST_WB]   <= sb_load[ST_MEM];
      sb_dest[ST_WB]   <= sb_dest[ST_MEM];
      sb_valid[ST_MEM] <= sb_valid[ST_EXE];
      sb_wb_en[ST_MEM] <= sb_wb_en[ST_EXE];
      sb_load[ST_MEM]  <= sb_load[ST_EXE];
      sb_dest[ST_MEM]  <= sb_dest[ST_EXE];
      if (bubble) begin
        sb_valid[ST_EXE] <= 1'b0;
        sb_wb_en[ST_EXE] <= 1'b0;
        sb_load[ST_EXE]  <= 1'b0;
        sb_dest[ST_EXE]  <= '0;
      end else begin
        sb_valid[ST_EXE] <= 1'b1;
        sb_wb_en[ST_EXE] <= id_wb_en;
        sb_load[ST_EXE]  <= id_mem_r_en;
        sb_dest[ST_EXE]  <= id_dest;
      end
      if (hazard_detected && stall_count != '1)
        stall_count <= stall_count + 1'b1;
    end
  end

`ifdef HAZARD_FORWARDING_EN
  fwd_sel_t sel1_q;
  fwd_sel_t sel2_q;

  // Selects travel with the instruction entering EXE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel1_q <= FWD_REGFILE;
      sel2_q <= FWD_REGFILE;
    end else if (advance) begin
      if (bubble) begin
        sel1_q <= FWD_REGFILE;
        sel2_q <= FWD_REGFILE;
      end else begin
        sel1_q <= fwd_pick(hit1[ST_MEM:ST_EXE]);
        sel2_q <= fwd_pick(hit2_g[ST_MEM:ST_EXE]);
      end
    end
  end

  assign fwd_src1_sel = sel1_q;
  assign fwd_src2_sel = sel2_q;
`else
  assign fwd_src1_sel = FWD_REGFILE;
  assign fwd_src2_sel = FWD_REGFILE;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized scoreboard bench for hazard_scoreboard against a
// reference model of in-flight producers.
module tb_hazard_scoreboard;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] id_src1 = '0;
  logic [AW-1:0] id_src2 = '0;
  logic          id_two_src = 1'b0;
  logic          id_valid = 1'b0;
  logic          id_wb_en = 1'b0;
  logic          id_mem_r_en = 1'b0;
  logic [AW-1:0] id_dest = '0;
  logic          branch_taken = 1'b0;
  logic          mem_ready = 1'b1;
  logic          hazard_detected;
  logic          flush;
  logic          freeze;
  logic [1:0]    fwd_src1_sel;
  logic [1:0]    fwd_src2_sel;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_ADDR_W  (AW),
    .STALL_CNT_W (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_two_src      (id_two_src),
    .id_valid        (id_valid),
    .id_wb_en        (id_wb_en),
    .id_mem_r_en     (id_mem_r_en),
    .id_dest         (id_dest),
    .branch_taken    (branch_taken),
    .mem_ready       (mem_ready),
    .hazard_detected (hazard_detected),
    .flush           (flush),
    .freeze          (freeze),
    .fwd_src1_sel    (fwd_src1_sel),
    .fwd_src2_sel    (fwd_src2_sel),
    .stall_count     (stall_count)
  );

  typedef struct packed {
    logic          haz;
    logic          fl;
    logic          fz;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [CW-1:0] cnt;
  } exp_t;

  // An in-flight instruction; s1/s2 are the selects it carries in EXE
  typedef struct packed {
    bit       v;
    bit       wr;
    bit [4:0] d;
    bit       ld;
    bit [1:0] s1;
    bit [1:0] s2;
  } slot_t;

  exp_t    q[$];
  int      checks = 0;
  int      errors = 0;
  slot_t   pipe [3];
  int      m_cnt = 0;
  bit      last_haz = 0;
  bit      last_frz = 0;

  function automatic bit writes(input slot_t s, input bit [4:0] r);
    return s.v && s.wr && r != 0 && s.d == r;
  endfunction

  function automatic bit reads(input slot_t s);
    return writes(s, id_src1) ||
           (id_two_src && writes(s, id_src2));
  endfunction

  function automatic bit model_haz();
    bit stall;
`ifdef HAZARD_FORWARDING_EN
    stall = reads(pipe[0]) && pipe[0].ld;
`else
    stall = reads(pipe[0]) || reads(pipe[1]);
`endif
    return id_valid && !branch_taken && stall;
  endfunction

  function automatic bit [1:0] pick(input bit [4:0] r, input bit en);
    if (en && writes(pipe[0], r)) return 2'd1;
    if (en && writes(pipe[1], r)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_cnt = 0;
  endtask

  task automatic model_advance();
    bit    h;
    slot_t n;
    h = model_haz();
    if (!mem_ready) return;
    n = '0;
    if (!(h || branch_taken || !id_valid)) begin
      n.v  = 1;
      n.wr = id_wb_en;
      n.d  = id_dest;
      n.ld = id_mem_r_en;
`ifdef HAZARD_FORWARDING_EN
      n.s1 = pick(id_src1, 1'b1);
      n.s2 = pick(id_src2, id_two_src);
`endif
    end
    if (h && m_cnt < (1 << CW) - 1) m_cnt++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = n;
  endtask

  task automatic push_expect();
    exp_t e;
    e.haz = model_haz();
    e.fl  = branch_taken;
    e.fz  = !mem_ready;
    e.s1  = pipe[0].s1;
    e.s2  = pipe[0].s2;
    e.cnt = CW'(m_cnt);
    last_haz = e.haz;
    last_frz = e.fz;
    q.push_back(e);
  endtask

  task automatic drive(
    input bit v, input bit wb, input bit ld,
    input bit [4:0] d, input bit [4:0] a, input bit [4:0] b,
    input bit two, input bit br, input bit mr
  );
    @(posedge clk);
    if (rst) model_advance();
    #1;
    id_valid     = v;
    id_wb_en     = wb;
    id_mem_r_en  = ld;
    id_dest      = d;
    id_src1      = a;
    id_src2      = b;
    id_two_src   = two;
    branch_taken = br;
    mem_ready    = mr;
    push_expect();
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               n, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hazard", hazard_detected, e.haz);
        chk("flush", flush, e.fl);
        chk("freeze", freeze, e.fz);
        chk("fwd1", fwd_src1_sel, e.s1);
        chk("fwd2", fwd_src2_sel, e.s2);
        chk("stall_count", stall_count, e.cnt);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    if (rst) model_advance();
    #1;
    rst = 1'b0;
    model_reset();
    push_expect();
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_expect();
  endtask

  initial begin : stim
    bit [4:0] d, a, b;
    model_reset();
    #1;
    push_expect();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    push_expect();

    // ADD r3 ; ADD r4,r3,r1
    drive(1, 1, 0, 3, 1, 2, 1, 0, 1);
    repeat (3) drive(1, 1, 0, 4, 3, 1, 1, 0, 1);
    repeat (3) nop();
    // LD r5 ; SUB r6,r5,r5
    drive(1, 1, 1, 5, 1, 0, 0, 0, 1);
    repeat (3) drive(1, 1, 0, 6, 5, 5, 1, 0, 1);
    repeat (3) nop();
    // ADDI r0 ; ADD r7,r0,r0
    drive(1, 1, 0, 0, 1, 0, 0, 0, 1);
    repeat (2) drive(1, 1, 0, 7, 0, 0, 1, 0, 1);
    // Taken branch with dependent ID instruction
    drive(1, 1, 0, 8, 1, 0, 0, 0, 1);
    drive(1, 1, 0, 9, 8, 8, 1, 1, 1);
    drive(1, 1, 0, 9, 8, 8, 1, 0, 1);
    repeat (3) nop();
    // Freeze during a stall, then resume
    drive(1, 1, 1, 10, 1, 0, 0, 0, 1);
    drive(1, 1, 0, 11, 10, 0, 0, 0, 1);
    repeat (3) drive(1, 1, 0, 11, 10, 0, 0, 0, 0);
    repeat (3) drive(1, 1, 0, 11, 10, 0, 0, 0, 1);
    // Branch held across a freeze
    drive(1, 1, 0, 12, 1, 0, 0, 0, 1);
    repeat (2) drive(1, 1, 0, 13, 12, 0, 0, 1, 0);
    drive(1, 1, 0, 13, 12, 0, 0, 1, 1);
    repeat (2) nop();

    // Mid-run reset with EXE valid, then ID that would have matched
    drive(1, 1, 0, 14, 0, 0, 0, 0, 1);
    do_reset();
    drive(1, 1, 0, 15, 14, 14, 1, 0, 1);
    repeat (2) nop();

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (last_haz || last_frz) begin
        drive(id_valid, id_wb_en, id_mem_r_en, id_dest,
              id_src1, id_src2, id_two_src,
              last_frz ? branch_taken
                       : ($urandom_range(0, 9) == 0),
              $urandom_range(0, 6) != 0);
      end else begin
        d = 5'($urandom_range(0, 7));
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        drive($urandom_range(0, 7) != 0,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0,
              d, a, b,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 6) != 0);
      end
    end

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL coverage: got %0d checks expected >= 12", checks);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
